// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module  : apb_arb_pkg
// Brief   : Shared types and constants for the APB request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_STRB_W = CMD_DATA_W / 8;

    localparam logic PNSE_DEFAULT = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic                  write;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] strb;
        logic [2:0]            prot;
    } apb_cmd_t;

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module  : apb_rr_arbiter
// Brief   : Combinational round-robin pick: first request at or after i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_j;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // wrap the scan position back into 0..NUM_REQ-1
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_j = w_sum[IDX_W-1:0];
            if (i_en && !w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
        o_valid = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// Module  : apb_req_arbiter
// Brief   : Shares one APB requester port among NUM_REQ command sources.
//           Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]           req_prot,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_slverr,
    output logic [ADDR_WIDTH-1:0]          paddr,
    output logic [2:0]                     pprot,
    output logic                           pnse,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic                           pready,
    input  logic [DATA_WIDTH-1:0]          prdata,
    input  logic                           pslverr
);

    localparam int c_IDX_W  = $clog2(NUM_REQ);
    localparam int c_STRB_W = DATA_WIDTH / 8;

    state_e                  r_state, w_next;
    logic [c_IDX_W-1:0]      r_ptr, r_owner, w_idx;
    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_any, w_done, w_to;
    apb_cmd_t                w_sel;

    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [2:0]              r_pprot;
    logic                    r_pnse, r_psel, r_penable, r_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata, r_rsp_rdata;
    logic [c_STRB_W-1:0]     r_pstrb;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic                    r_rsp_slverr;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (r_state == IDLE),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel       = '0;
        w_sel.addr  = CMD_ADDR_W'(req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH]);
        w_sel.write = req_write[w_idx];
        w_sel.wdata = CMD_DATA_W'(req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH]);
        w_sel.strb  = CMD_STRB_W'(req_strb[w_idx*c_STRB_W +: c_STRB_W]);
        w_sel.prot  = req_prot[w_idx*3 +: 3];
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_to_cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_to_cnt <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_to_cnt <= '0;
        end else if (r_state == ACCESS && !pready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // this cycle is the TIMEOUT_CYCLES-th stalled ACCESS cycle
    assign w_to = (r_state == ACCESS) && !pready &&
                  (r_to_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_to = 1'b0;
`endif

    assign w_done = (r_state == ACCESS) && (pready || w_to);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_paddr      <= '0;
            r_pprot      <= '0;
            r_pnse       <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
        end else begin
            r_pnse      <= PNSE_DEFAULT;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_paddr  <= w_sel.addr[ADDR_WIDTH-1:0];
                        r_pwrite <= w_sel.write;
                        r_pprot  <= w_sel.prot;
                        r_pstrb  <= w_sel.write ? w_sel.strb[c_STRB_W-1:0] : '0;
                        // reads leave pwdata at its previous value
                        if (w_sel.write) begin
                            r_pwdata <= w_sel.wdata[DATA_WIDTH-1:0];
                        end
                        r_psel  <= 1'b1;
                        r_owner <= w_idx;
                        r_ptr   <= (w_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_rdata          <= w_to ? '0 : prdata;
                        r_rsp_slverr         <= w_to | pslverr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign paddr      = r_paddr;
    assign pprot      = r_pprot;
    assign pnse       = r_pnse;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign pwdata     = r_pwdata;
    assign pstrb      = r_pstrb;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// Module  : tb_apb_req_arbiter
// Brief   : Self-checking bench for apb_req_arbiter (transaction-level model
//           plus directed literal checks). Honours APB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            pclk = 1'b0;
    logic            preset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_strb = '0;
    logic [N*3-1:0]  req_prot = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            pnse, psel, penable, pwrite;
    logic [DW-1:0]   pwdata;
    logic [SW-1:0]   pstrb;
    logic            pready = 1'b0;
    logic [DW-1:0]   prdata = '0;
    logic            pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_req_arbiter dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .paddr(paddr), .pprot(pprot), .pnse(pnse),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model: one outstanding command, aged in cycles.
    int            m_ptr = 0, m_age = 0, m_owner = 0, m_cnt = 0, m_w = 0;
    bit            m_busy = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_write = 1'b0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [SW-1:0] m_strb = '0;
    logic [2:0]    m_prot = '0;
    logic [N-1:0]  m_rsp = '0;
    logic          m_err = 1'b0;

    task automatic m_finish(input logic [DW-1:0] d, input logic e);
        m_rsp          = '0;
        m_rsp[m_owner] = 1'b1;
        m_rdata        = d;
        m_err          = e;
        m_busy         = 1'b0;
    endtask

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_ptr = 0; m_busy = 0; m_age = 0; m_rsp = '0; m_cnt = 0;
            m_addr = '0; m_write = 0; m_wdata = '0; m_strb = '0; m_prot = '0;
        end else begin
            m_rsp = '0;
            if (!m_busy) begin
                m_w = rr_pick(req_valid, m_ptr);
                if (m_w >= 0) begin
                    m_addr  = req_addr[m_w*AW +: AW];
                    m_write = req_write[m_w];
                    if (m_write) m_wdata = req_wdata[m_w*DW +: DW];
                    m_strb  = m_write ? req_strb[m_w*SW +: SW] : '0;
                    m_prot  = req_prot[m_w*3 +: 3];
                    m_owner = m_w;
                    m_ptr   = (m_w + 1) % N;
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_cnt   = 0;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (pready) begin
                m_finish(prdata, pslverr);
            end else begin
                m_cnt++;
`ifdef APB_TIMEOUT_EN
                if (m_cnt == TO) m_finish('0, 1'b1);
`endif
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            m_w = m_busy ? -1 : rr_pick(req_valid, m_ptr);
            chk("req_ready", req_ready, (m_w >= 0) ? (64'd1 << m_w) : 64'd0);
            chk("psel", psel, m_busy);
            chk("penable", penable, m_busy && m_age >= 2);
            chk("pnse", pnse, 0);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_busy) begin
                chk("paddr", paddr, m_addr);
                chk("pwrite", pwrite, m_write);
                chk("pwdata", pwdata, m_wdata);
                chk("pstrb", pstrb, m_strb);
                chk("pprot", pprot, m_prot);
            end
            if (m_rsp != '0) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_slverr", rsp_slverr, m_err);
            end
        end
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge pclk);
    endtask

    task automatic set_req(input int s, input logic [AW-1:0] a, input logic wr,
                           input logic [DW-1:0] d, input logic [SW-1:0] st,
                           input logic [2:0] pr);
        req_valid[s]          = 1'b1;
        req_addr[s*AW +: AW]  = a;
        req_write[s]          = wr;
        req_wdata[s*DW +: DW] = d;
        req_strb[s*SW +: SW]  = st;
        req_prot[s*3 +: 3]    = pr;
    endtask

    task automatic reset_pulse;
        tick; preset = 1'b1;
        tick; preset = 1'b0;
    endtask

    int g, nr;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #1 preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        chk_en = 1'b1;

        // reset state
        at_neg;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);

        // zero-wait write from src1
        tick; set_req(1, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0); pready = 1'b1;
        at_neg; chk("t1_ready_c0", req_ready, 4'b0010);
        tick; req_valid = '0;
        at_neg; chk("t1_psel_c1", psel, 1); chk("t1_penable_c1", penable, 0);
        tick; at_neg; chk("t1_penable_c2", penable, 1); chk("t1_paddr_c2", paddr, 32'h40);
        tick; at_neg; chk("t1_rsp_c3", rsp_valid, 4'b0010); chk("t1_slverr_c3", rsp_slverr, 0);

        // read from src0 with three wait states
        tick; set_req(0, 32'h80, 1'b0, 32'h0, 4'hF, 3'b010);
        pready = 1'b0; prdata = 32'h12345678;
        at_neg; chk("t2_ready_c0", req_ready, 4'b0001);
        tick; req_valid = '0;
        tick; tick; tick;
        tick; pready = 1'b1;
        at_neg; chk("t2_pstrb_c5", pstrb, 0); chk("t2_pwdata_hold_c5", pwdata, 32'hDEADBEEF);
        chk("t2_rsp_c5", rsp_valid, 0);
        tick; at_neg; chk("t2_rsp_c6", rsp_valid, 4'b0001); chk("t2_rdata_c6", rsp_rdata, 32'h12345678);

        // all four sources contend continuously
        reset_pulse;
        tick;
        for (int s = 0; s < N; s++) set_req(s, AW'(32'h100 * (s + 1)), s[0], DW'(32'hA0 + s), 4'h5, 3'(s));
        g = 0; nr = 0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int c = 0; c < 60 && (g < 5 || nr < 5); c++) begin
            at_neg;
            if (rsp_valid != '0) nr++;
            if (req_ready != '0 && g < 5) begin
                order[g] = $clog2(req_ready);
                chk("t3_psel_gap", psel, 0);
                g++;
            end
            tick;
            if (g == 5) req_valid = '0;
        end
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), order[i], exp_order[i]);
        chk("t3_rsp_count", nr, 5);

        // slave error on a src2 write, then a clean src3 read
        tick; set_req(2, 32'h200, 1'b1, 32'hCAFEF00D, 4'h3, 3'd1); pready = 1'b1; pslverr = 1'b1;
        at_neg; chk("t4_ready", req_ready, 4'b0100);
        tick; req_valid = '0;
        tick; tick;
        at_neg; chk("t4_rsp", rsp_valid, 4'b0100); chk("t4_slverr", rsp_slverr, 1);
        tick; pslverr = 1'b0; set_req(3, 32'h300, 1'b0, 32'h0, 4'h0, 3'd2); prdata = 32'h0BADBEEF;
        at_neg; chk("t4b_ready", req_ready, 4'b1000);
        tick; req_valid = '0;
        tick; tick;
        at_neg; chk("t4b_rsp", rsp_valid, 4'b1000); chk("t4b_slverr", rsp_slverr, 0);

        // reset during ACCESS
        tick; set_req(1, 32'h44, 1'b1, 32'h55AA55AA, 4'hF, 3'd0); pready = 1'b0;
        tick; req_valid = '0;
        tick; at_neg; chk("t5_penable_pre", penable, 1);
        tick; preset = 1'b1;
        #1; chk("t5_psel_rst", psel, 0); chk("t5_penable_rst", penable, 0);
        at_neg; chk("t5_rsp_rst", rsp_valid, 0);
        tick; preset = 1'b0; pready = 1'b1;
        at_neg; chk("t5_rsp_after", rsp_valid, 0);
        tick; set_req(3, 32'h330, 1'b1, 32'h33, 4'h1, 3'd0); set_req(0, 32'h000, 1'b1, 32'h11, 4'h2, 3'd0);
        at_neg; chk("t5_ptr0_ready", req_ready, 4'b0001);
        tick; req_valid = '0;
        tick; tick;
        at_neg; chk("t5_rsp", rsp_valid, 4'b0001);

        // pready held low
        tick; set_req(2, 32'h600, 1'b0, 32'h0, 4'h0, 3'd5); pready = 1'b0; prdata = 32'hA5A5A5A5;
        at_neg; chk("t6_ready", req_ready, 4'b0100);
        tick; req_valid = '0;
`ifdef APB_TIMEOUT_EN
        repeat (16) tick;
        at_neg; chk("t6_rsp_c17", rsp_valid, 0); chk("t6_penable_c17", penable, 1);
        tick;
        at_neg; chk("t6_rsp_c18", rsp_valid, 4'b0100); chk("t6_slverr", rsp_slverr, 1);
        chk("t6_rdata", rsp_rdata, 0);
        tick;
        at_neg; chk("t6_idle", psel, 0);
`else
        repeat (100) tick;
        at_neg; chk("t6_pending_psel", psel, 1); chk("t6_pending_penable", penable, 1);
        chk("t6_pending_rsp", rsp_valid, 0);
        reset_pulse;
`endif

        tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB requester port among NUM_REQ internal command sources.
- Each source issues single-transfer commands over a valid/ready interface and receives one response pulse per command.
- Round-robin arbitration selects the next command; the block then sequences the APB SETUP and ACCESS phases and returns prdata and pslverr to the winning source.
- Sits between bus-master logic (DMA, CPU bridge, test sequencer) and the APB interconnect.

Parameters:
- NUM_REQ, 4, number of command sources (2..8).
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width (8, 16 or 32).
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock; all state changes on the rising edge.
- preset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-source command valid.
- req_ready  out  NUM_REQ  per-source accept, one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-source address; source i occupies slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  write strobes.
- req_prot  in  NUM_REQ*3  pprot value.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse for the owning source.
- rsp_rdata  out  DATA_WIDTH  read data; shared by all sources and valid only with rsp_valid.
- rsp_slverr  out  1  error flag; valid only with rsp_valid.
- paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb  out  APB widths  APB requester outputs.
- pready, prdata, pslverr  in  1, DATA_WIDTH, 1  APB completer inputs.

Behaviour:
- Clocking and reset: one clock, pclk. Reset is asynchronous and active-high on preset.
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0.
- Output timing: every APB output and every rsp_* output is driven from a flop. req_ready is combinational from req_valid, the pointer and the FSM state.
- IDLE:
  - If any req_valid is high, the first set bit at or after the pointer (wrapping) wins.
  - req_ready[winner] = 1 in that same cycle, and the command is latched on that edge.
  - pointer <= (winner+1) mod NUM_REQ.
  - Next state: SETUP.
- SETUP: psel=1, penable=0, with paddr/pwrite/pwdata/pprot/pstrb taken from the latched command. Next state: ACCESS, unconditionally.
- ACCESS:
  - psel=1, penable=1, all APB address/control/data outputs held stable.
  - When pready=1, capture prdata and pslverr, drive rsp_valid[owner]=1 next cycle, drop psel/penable next cycle, and return to IDLE.
- pnse: always 0.
- Reads: pstrb is driven 0 and pwdata holds its last value.
- Latency: accept in cycle 0, SETUP in cycle 1, ACCESS from cycle 2. Zero-wait completion gives rsp_valid in cycle 3. Each pready-low cycle adds 1.
- No back-to-back transfers: at least one IDLE cycle with psel=0 always separates transfers.
- req_ready stays 0 outside IDLE, so a source must hold req_valid and its command fields until it sees req_ready.
- A source whose req_valid drops before acceptance loses nothing; no state is kept per source.
- Simultaneous rsp_valid[i] and a new req_valid[i]: allowed; the new command competes normally in that IDLE cycle.
- pready/pslverr sampled outside ACCESS are ignored.
- Reset mid-transfer: psel/penable drop immediately, no rsp_valid is issued, and the in-flight command is lost.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter with width $clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles with pready=0.
  - Reaching TIMEOUT_CYCLES ends the transfer as though pready=1, with rsp_slverr=1 and rsp_rdata=0.
  - The counter clears on entry to SETUP.
- Undefined: no counter exists, and ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_arb_pkg contains:
  - state_e enum {IDLE, SETUP, ACCESS}.
  - apb_cmd_t struct {addr, write, wdata, strb, prot}, parameterized through package localparams matching the defaults.
  - PNSE_DEFAULT constant = 0.
- Sub-module apb_rr_arbiter: pure round-robin pick. It takes the request vector, pointer and enable, and returns a one-hot grant plus an index. It is combinational and instantiated once.

Test Plan:
- Reset, then src1 writes addr 0x40, data 0xDEADBEEF, strb 0xF, pready tied 1 → req_ready[1] in cycle 0, psel in cycle 1, penable in cycle 2, rsp_valid[1] in cycle 3 with slverr 0.
- Read with prdata=0x12345678 and pready low for 3 ACCESS cycles → rsp_valid in cycle 6, rsp_rdata=0x12345678, APB outputs stable throughout ACCESS.
- All 4 sources hold req_valid continuously → grant order 0,1,2,3,0, with exactly one rsp_valid per grant and at least one psel=0 cycle between transfers.
- pslverr=1 with pready=1 on a write by src2 → rsp_valid[2]=1, rsp_slverr=1, next transfer unaffected.
- preset asserted during ACCESS → psel=penable=0 immediately, no rsp_valid, pointer=0, next request accepted normally.
- With APB_TIMEOUT_EN and pready held 0 → rsp_slverr=1 and rsp_rdata=0 after 16 ACCESS cycles, then IDLE. Without the macro, the transfer is still pending after 100 cycles.
